// File: rtl/fread_arbiter_if.sv
// Client-side and fread-engine-side signals of the fread arbiter, bundled.
// The arbiter takes the slave modport; whatever drives clients and engine takes master.
interface fread_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]      c_req_valid;
    logic [N_REQ-1:0]      c_req_ready;
    logic [32*N_REQ-1:0]   c_req_file_id;
    logic [32*N_REQ-1:0]   c_req_offset;
    logic [11*N_REQ-1:0]   c_req_len;
    logic [N_REQ-1:0]      c_resp_valid;
    logic [7:0]            c_resp_data;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_file_id;
    logic [31:0]           req_offset;
    logic [10:0]           req_len;
    logic                  resp_valid;
    logic [7:0]            resp_data;
    logic                  busy;
    logic [IDX_W-1:0]      grant;

    modport slave (
        input  c_req_valid, c_req_file_id, c_req_offset, c_req_len,
        input  req_ready, resp_valid, resp_data,
        output c_req_ready, c_resp_valid, c_resp_data,
        output req_valid, req_file_id, req_offset, req_len, busy, grant
    );

    modport master (
        output c_req_valid, c_req_file_id, c_req_offset, c_req_len,
        output req_ready, resp_valid, resp_data,
        input  c_req_ready, c_resp_valid, c_resp_data,
        input  req_valid, req_file_id, req_offset, req_len, busy, grant
    );
endinterface

// File: rtl/fread_arbiter.sv
// Round-robin arbiter sharing one fread request/response channel among N_REQ clients.
// A grant is held from request issue until the last byte of that request has been routed.
module fread_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    fread_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_e;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_e            state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [31:0]       req_file_id_q, req_file_id_d;
    logic [31:0]       req_offset_q, req_offset_d;
    logic [10:0]       req_len_q, req_len_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              busy_q, busy_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    // Search starts just after the last served client, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pick_found && bus.c_req_valid[(32'(last_q) + i + 1) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((32'(last_q) + i + 1) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_file_id_d = req_file_id_q;
        req_offset_d  = req_offset_q;
        req_len_d     = req_len_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_d        = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_file_id_d = bus.c_req_file_id[32*pick_idx +: 32];
                    req_offset_d  = bus.c_req_offset[32*pick_idx +: 32];
                    req_len_d     = bus.c_req_len[11*pick_idx +: 11];
                    grant_d       = pick_idx;
                    cnt_d         = '0;
                    req_valid_d   = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (bus.resp_valid) begin
                    if (cnt_q == req_len_q) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_valid_q   <= 1'b0;
            req_file_id_q <= '0;
            req_offset_q  <= '0;
            req_len_q     <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            last_q        <= LAST_RST;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_file_id_q <= req_file_id_d;
            req_offset_q  <= req_offset_d;
            req_len_q     <= req_len_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
        end
    end

    // Accept pulse and byte strobe follow the engine inputs with no register stage.
    always_comb begin
        bus.c_req_ready  = '0;
        bus.c_resp_valid = '0;
        if (state_q == ISSUE && req_valid_q && bus.req_ready) begin
            bus.c_req_ready[grant_q] = 1'b1;
        end
        if (state_q == STREAM && bus.resp_valid) begin
            bus.c_resp_valid[grant_q] = 1'b1;
        end
    end

    assign bus.c_resp_data = bus.resp_data;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_file_id = req_file_id_q;
    assign bus.req_offset  = req_offset_q;
    assign bus.req_len     = req_len_q;
    assign bus.busy        = busy_q;
    assign bus.grant       = grant_q;
endmodule

// File: tb/tb_fread_arbiter.sv
// Bench for fread_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model (owner, bytes remaining, last served).
module tb_fread_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fread_arbiter_if #(.N_REQ(N), .IDX_W(IW)) bus();

    fread_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: is a request owned, has it been handed to the engine, bytes still due.
    bit          m_active = 1'b0;
    bit          m_issued = 1'b0;
    int          m_owner  = 0;
    int          m_left   = 0;
    int          m_last   = N - 1;
    logic [31:0] m_fid    = '0;
    logic [31:0] m_off    = '0;
    logic [10:0] m_len    = '0;

    int          rc  [N];
    int          rdy [N];
    logic [N-1:0] acc = '0;

    initial begin
        for (int k = 0; k < N; k++) begin
            rc[k]  = 0;
            rdy[k] = 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] onehot;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        int c;
        onehot = '0;
        onehot[m_owner] = 1'b1;
        exp_rdy = (m_active && !m_issued && bus.req_ready) ? onehot : '0;
        exp_rsp = (m_active && m_issued && bus.resp_valid) ? onehot : '0;
        chk("busy",         bus.busy,         m_active);
        chk("req_valid",    bus.req_valid,    m_active && !m_issued);
        chk("grant",        bus.grant,        m_owner);
        chk("req_file_id",  bus.req_file_id,  m_fid);
        chk("req_offset",   bus.req_offset,   m_off);
        chk("req_len",      bus.req_len,      m_len);
        chk("c_req_ready",  bus.c_req_ready,  exp_rdy);
        chk("c_resp_valid", bus.c_resp_valid, exp_rsp);
        chk("c_resp_data",  bus.c_resp_data,  bus.resp_data);
        for (int k = 0; k < N; k++) begin
            rc[k]  += int'(bus.c_resp_valid[k]);
            rdy[k] += int'(bus.c_req_ready[k]);
        end
        acc = bus.c_req_ready;

        if (rst) begin
            m_active = 1'b0;
            m_issued = 1'b0;
            m_owner  = 0;
            m_last   = N - 1;
            m_fid    = '0;
            m_off    = '0;
            m_len    = '0;
        end else if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!m_active && bus.c_req_valid[c]) begin
                    m_active = 1'b1;
                    m_issued = 1'b0;
                    m_owner  = c;
                    m_fid    = bus.c_req_file_id[32*c +: 32];
                    m_off    = bus.c_req_offset[32*c +: 32];
                    m_len    = bus.c_req_len[11*c +: 11];
                    m_left   = int'(m_len) + 1;
                end
            end
        end else if (!m_issued) begin
            if (bus.req_ready) m_issued = 1'b1;
        end else if (bus.resp_valid) begin
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_last   = m_owner;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.c_req_valid   = '0;
        bus.c_req_file_id = '0;
        bus.c_req_offset  = '0;
        bus.c_req_len     = '0;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_data     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin : main
        int base;
        int base_r;
        int got[$];

        clear_inputs();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_grant", bus.grant,     0);
        chk("rst_rv",    bus.req_valid, 0);

        // Single client, 4-byte read.
        do_reset();
        bus.c_req_valid[0]        = 1'b1;
        bus.c_req_file_id[31:0]   = 32'hDABBAD00;
        bus.c_req_offset[31:0]    = 32'h0000_0800;
        bus.c_req_len[10:0]       = 11'd3;
        base_r = rdy[0];
        cyc();
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_valid", bus.req_valid,   1);
        chk("t1_file_id",   bus.req_file_id, 32'hDABBAD00);
        chk("t1_offset",    bus.req_offset,  32'h800);
        chk("t1_len",       bus.req_len,     3);
        chk("t1_c_ready",   bus.c_req_ready, 2'b01);
        cyc();
        bus.c_req_valid = '0;
        bus.req_ready   = 1'b0;
        base = rc[0];
        for (int b = 0; b < 4; b++) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = 8'(8'h11 * (b + 1));
            @(negedge clk);
            chk("t1_resp_valid", bus.c_resp_valid, 2'b01);
            chk("t1_resp_data",  bus.c_resp_data,  8'(8'h11 * (b + 1)));
            cyc();
        end
        bus.resp_valid = 1'b0;
        @(negedge clk);
        chk("t1_idle",       bus.busy,        0);
        chk("t1_byte_count", rc[0] - base,    4);
        chk("t1_ready_once", rdy[0] - base_r, 1);

        // Contention: both clients, one byte each; client 0 first after reset.
        do_reset();
        bus.c_req_valid             = 2'b11;
        bus.c_req_file_id[31:0]     = 32'h0000_00A0;
        bus.c_req_file_id[63:32]    = 32'h0000_00B1;
        cyc();
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk("t2_grant0", bus.grant,       0);
        chk("t2_fid0",   bus.req_file_id, 32'hA0);
        chk("t2_rdy0",   bus.c_req_ready, 2'b01);
        cyc();
        bus.c_req_valid[0] = 1'b0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b1;
        @(negedge clk);
        chk("t2_byte0", bus.c_resp_valid, 2'b01);
        cyc();
        bus.resp_valid = 1'b0;
        @(negedge clk);
        chk("t2_gap_rv", bus.req_valid, 0);
        cyc();
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk("t2_rv_rise", bus.req_valid,   1);
        chk("t2_grant1",  bus.grant,       1);
        chk("t2_fid1",    bus.req_file_id, 32'hB1);
        chk("t2_rdy1",    bus.c_req_ready, 2'b10);
        cyc();
        bus.c_req_valid = '0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b1;
        @(negedge clk);
        chk("t2_byte1", bus.c_resp_valid, 2'b10);
        cyc();
        bus.resp_valid = 1'b0;

        // Fairness: both clients requesting continuously.
        do_reset();
        bus.c_req_valid = 2'b11;
        bus.req_ready   = 1'b1;
        bus.resp_valid  = 1'b1;
        for (int i = 0; i < 60 && got.size() < 6; i++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) got.push_back(int'(bus.grant));
        end
        chk("t3_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) chk("t3_grant_seq", got[i], i % 2);
        cyc();

        // Backpressure: engine holds off for 5 cycles.
        do_reset();
        bus.c_req_valid[1]       = 1'b1;
        bus.c_req_file_id[63:32] = 32'h1234_5678;
        bus.c_req_offset[63:32]  = 32'h0000_0055;
        bus.c_req_len[21:11]     = 11'd1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_rv_hold",  bus.req_valid,   1);
            chk("t4_fid_hold", bus.req_file_id, 32'h12345678);
            chk("t4_off_hold", bus.req_offset,  32'h55);
            chk("t4_no_rdy",   bus.c_req_ready, 2'b00);
            cyc();
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        chk("t4_rdy", bus.c_req_ready, 2'b10);
        cyc();
        bus.c_req_valid = '0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b1;
        cyc();
        cyc();
        bus.resp_valid = 1'b0;

        // Stray bytes while idle, then reset in the middle of a transfer.
        do_reset();
        bus.resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_stray", bus.c_resp_valid, 2'b00);
            cyc();
        end
        bus.resp_valid         = 1'b0;
        bus.c_req_valid[0]     = 1'b1;
        bus.c_req_file_id[31:0] = 32'hCAFE_0007;
        bus.c_req_len[10:0]    = 11'd7;
        cyc();
        bus.req_ready = 1'b1;
        cyc();
        bus.c_req_valid = '0;
        bus.req_ready   = 1'b0;
        base = rc[0];
        bus.resp_valid  = 1'b1;
        cyc();
        cyc();
        bus.resp_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", bus.busy,        0);
        chk("t5_rst_rv",   bus.req_valid,   0);
        chk("t5_rst_len",  bus.req_len,     0);
        chk("t5_rst_fid",  bus.req_file_id, 0);
        cyc();
        bus.resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_late_byte", bus.c_resp_valid, 2'b00);
            cyc();
        end
        bus.resp_valid = 1'b0;
        @(negedge clk);
        chk("t5_routed", rc[0] - base, 2);

        // Maximum length: 2048 bytes back to back.
        do_reset();
        bus.c_req_valid[1]   = 1'b1;
        bus.c_req_len[21:11] = 11'd2047;
        bus.req_ready        = 1'b1;
        cyc();
        cyc();
        bus.c_req_valid = '0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b1;
        base = rc[1];
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        chk("t6_done",  bus.busy,     0);
        chk("t6_bytes", rc[1] - base, 2048);
        cyc();
        bus.resp_valid = 1'b0;

        // Random traffic, occasional resets.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            cyc();
            for (int k = 0; k < N; k++) begin
                if (acc[k]) bus.c_req_valid[k] = 1'b0;
                if (!bus.c_req_valid[k] && $urandom_range(3) == 0) begin
                    bus.c_req_valid[k]          = 1'b1;
                    bus.c_req_file_id[32*k +: 32] = $urandom();
                    bus.c_req_offset[32*k +: 32]  = $urandom();
                    bus.c_req_len[11*k +: 11]     = ($urandom_range(7) == 0) ?
                                                    11'($urandom_range(63)) :
                                                    11'($urandom_range(3));
                end
            end
            bus.req_ready  = 1'($urandom_range(1));
            bus.resp_valid = ($urandom_range(9) < 6);
            bus.resp_data  = 8'($urandom());
            rst            = ($urandom_range(499) == 0);
        end
        cyc();
        rst = 1'b0;
        clear_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
